// File: rtl/uart_tx_param.sv
// uart_tx_param: parameterised UART transmitter, LSB first, optional parity.
// Define UART_TX_FIFO_EN to add a FIFO_DEPTH-entry transmit FIFO.
module uart_tx_param #(
  parameter int DATA_W      = 8,
  parameter int CLK_DIV     = 5208,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy
);

  localparam int CW = $clog2(CLK_DIV);

  // An illegal configuration never raises tx_ready.
  localparam bit CFG_OK = (DATA_W >= 5) && (DATA_W <= 9) &&
    (CLK_DIV >= 2) && (PARITY_MODE >= 0) && (PARITY_MODE <= 2) &&
    ((STOP_BITS == 1) || (STOP_BITS == 2)) && (FIFO_DEPTH >= 2) &&
    ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     baud_cnt;
  logic [3:0]        bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] load_data;
  logic              par_bit;
  logic              rdy_en;
  logic              tick;
  logic              last_bit;
  logic              avail;
  logic              load;
  logic              tx_nxt;

  assign tick = (baud_cnt == CW'(CLK_DIV - 1));

  assign last_bit = (state == DATA) ?
    (bit_cnt == 4'(DATA_W - 1)) :
    (bit_cnt == 4'(STOP_BITS - 1));

  assign load = avail &&
    ((state == IDLE) ||
     ((state == STOP) && tick && last_bit));

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              push;
  logic              full;

  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign tx_ready  = rdy_en && !full;
  assign push      = tx_valid && tx_ready;
  assign avail     = (count != '0);
  assign load_data = mem[rd_ptr];
  assign busy      = (state != IDLE) || avail;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, load})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end
`else
  assign tx_ready  = rdy_en && (state == IDLE);
  assign avail     = tx_valid && tx_ready;
  assign load_data = tx_data;
  assign busy      = (state != IDLE);
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (avail) state_nxt = START;
      START:
        if (tick) state_nxt = DATA;
      DATA:
        if (tick && last_bit)
          state_nxt = (PARITY_MODE != 0) ? PARITY : STOP;
      PARITY:
        if (tick) state_nxt = STOP;
      STOP:
        if (tick && last_bit)
          state_nxt = avail ? START : IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_nxt = 1'b1;
    unique case (state)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shreg[0];
      PARITY:  tx_nxt = par_bit;
      default: tx_nxt = 1'b1;
    endcase
  end

  // tx_out is registered, so the line lags the state by one cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rdy_en   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx_out   <= 1'b1;
    end else begin
      rdy_en <= CFG_OK;
      if ((state == IDLE) || tick) baud_cnt <= '0;
      else                         baud_cnt <= baud_cnt + 1'b1;
      if (((state == DATA) || (state == STOP)) && tick)
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      if (load) begin
        shreg   <= load_data;
        par_bit <= (^load_data) ^ (PARITY_MODE == 2);
      end else if ((state == DATA) && tick) begin
        shreg <= shreg >> 1;
      end
      tx_out <= tx_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: scoreboard bench for uart_tx_param over four configs.
// Serial frames are decoded per instance and checked against queued words.
module tb_uart_tx_param;

  localparam int CD = 4;
  localparam int NI = 4;
`ifdef UART_TX_FIFO_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  function automatic int dw_of(int i);
    return (i == 3) ? 9 : 8;
  endfunction
  function automatic int pm_of(int i);
    return (i == 1) ? 1 : ((i == 2) ? 2 : 0);
  endfunction
  function automatic int sb_of(int i);
    return (i == 1) ? 2 : 1;
  endfunction
  function automatic int flen(int i);
    return CD * (1 + dw_of(i) + ((pm_of(i) != 0) ? 1 : 0) + sb_of(i));
  endfunction

  typedef struct {
    int         inst;
    logic [8:0] data;
    int         acc;
  } item_t;

  item_t exp_q[$];

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [8:0] tx_data [NI];
  logic       tx_valid [NI];
  logic       tx_ready [NI];
  logic       tx_out [NI];
  logic       busy [NI];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_i
    localparam int DW = dw_of(g);
    localparam int PM = pm_of(g);
    localparam int SB = sb_of(g);
    bit mon_busy = 1'b0;

    uart_tx_param #(
      .DATA_W(DW), .CLK_DIV(CD), .PARITY_MODE(PM),
      .STOP_BITS(SB), .FIFO_DEPTH(4)
    ) u_dut (
      .clk(clk), .n_rst(n_rst),
      .tx_data(tx_data[g][DW-1:0]), .tx_valid(tx_valid[g]),
      .tx_ready(tx_ready[g]), .tx_out(tx_out[g]), .busy(busy[g])
    );

    initial begin : mon
      int prev_end;
      int nb;
      int bad;
      int bbad;
      int abort;
      int exp_s;
      logic p;
      logic [15:0] bits;
      item_t it;
      prev_end = -1000;
      forever begin
        @(negedge clk);
        if (!n_rst) begin
          prev_end = -1000;
          continue;
        end
        if (tx_out[g] !== 1'b0) continue;
        mon_busy = 1'b1;
        if (exp_q.size() == 0 || exp_q[0].inst != g) begin
          chk($sformatf("unexpected_start_i%0d", g), 1, 0);
          for (int t = 0; t < 200 && tx_out[g] === 1'b0 && n_rst; t++)
            @(negedge clk);
          mon_busy = 1'b0;
          continue;
        end
        it = exp_q.pop_front();
        exp_s = (it.acc + LAT > prev_end + 1) ? it.acc + LAT : prev_end + 1;
        chk($sformatf("start_cycle_i%0d_w%03h", g, it.data), cyc, exp_s);
        bits = '1;
        bits[0] = 1'b0;
        for (int j = 0; j < DW; j++) bits[1 + j] = it.data[j];
        nb = 1 + DW;
        if (PM != 0) begin
          p = ($countones(it.data[DW-1:0]) % 2) == 1;
          if (PM == 2) p = !p;
          bits[nb] = p;
          nb++;
        end
        nb = nb + SB;
        abort = 0;
        bbad = 0;
        for (int b = 0; b < nb && abort == 0; b++) begin
          bad = 0;
          for (int k = 0; k < CD; k++) begin
            if (b != 0 || k != 0) begin
              @(negedge clk);
              if (!n_rst) begin
                abort = 1;
                break;
              end
            end
            if (tx_out[g] !== bits[b]) bad = 1;
            if (!(b == nb - 1 && k == CD - 1) && busy[g] !== 1'b1) bbad = 1;
          end
          if (abort == 0)
            chk($sformatf("i%0d_w%03h_bit%0d", g, it.data, b), bad, 0);
        end
        if (abort == 0) begin
          chk($sformatf("i%0d_w%03h_busy_in_frame", g, it.data), bbad, 0);
          prev_end = cyc;
        end else begin
          prev_end = -1000;
        end
        mon_busy = 1'b0;
      end
    end
  end

  function automatic bit any_busy();
    return g_i[0].mon_busy || g_i[1].mon_busy ||
           g_i[2].mon_busy || g_i[3].mon_busy ||
           busy[0] || busy[1] || busy[2] || busy[3];
  endfunction

  // Called just after a negedge; returns just after the negedge that
  // follows the accepting edge, with tx_valid still high.
  task automatic drive(input int i, input logic [8:0] d, output int acc);
    logic [8:0] m;
    int t;
    m = 9'((1 << dw_of(i)) - 1);
    tx_valid[i] = 1'b1;
    tx_data[i] = d;
    acc = -1;
    t = 0;
    while (acc < 0 && t < 2000) begin
      #4;
      if (tx_ready[i] === 1'b1) begin
        acc = cyc + 1;
        exp_q.push_back('{inst: i, data: d & m, acc: acc});
      end
      @(negedge clk);
      t++;
    end
    if (acc < 0) chk($sformatf("accept_timeout_i%0d", i), 1, 0);
  endtask

  task automatic release_v(input int i);
    tx_valid[i] = 1'b0;
    tx_data[i] = 9'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (t < 3000 && (exp_q.size() != 0 || any_busy())) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", (t >= 3000) ? 1 : 0, 0);
    if (t >= 3000) exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int a0;
    int r;
    int t;
    int gap;
    logic [8:0] d;
    for (int i = 0; i < NI; i++) begin
      tx_valid[i] = 1'b0;
      tx_data[i] = '0;
    end
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_tx_out_i%0d", i), int'(tx_out[i]), 1);
      chk($sformatf("rst_busy_i%0d", i), int'(busy[i]), 0);
      chk($sformatf("rst_ready_i%0d", i), int'(tx_ready[i]), 0);
    end
    #2 n_rst = 1'b1;
    #1 chk("ready_before_first_edge", int'(tx_ready[0]), 0);
    @(posedge clk);
    #1 chk("ready_after_first_edge", int'(tx_ready[0]), 1);
    @(negedge clk);

    drive(0, 9'h0A5, acc); release_v(0); drain();
    drive(1, 9'h007, acc); release_v(1); drain();
    drive(2, 9'h007, acc); release_v(2); drain();
    drive(3, 9'h1FF, acc); release_v(3); drain();

`ifdef UART_TX_FIFO_EN
    drive(1, 9'h000, acc);
    drive(1, 9'h0FF, acc);
    release_v(1);
    drain();

    a0 = -1;
    for (int c = 0; c < 6; c++) begin
      d = 9'($urandom);
      tx_valid[1] = 1'b1;
      tx_data[1] = d;
      #4;
      r = int'(tx_ready[1]);
      chk($sformatf("hold_ready_c%0d", c), r, (c < 5) ? 1 : 0);
      if (r == 1) begin
        exp_q.push_back('{inst: 1, data: d & 9'h0FF, acc: cyc + 1});
        if (c == 0) a0 = cyc + 1;
      end
      @(negedge clk);
    end
    t = 0;
    r = 0;
    while (r == 0 && t < 2000) begin
      #4;
      if (tx_ready[1] === 1'b1) begin
        chk("ready_return_cycle", cyc, a0 + 1 + flen(1));
        exp_q.push_back('{inst: 1, data: d & 9'h0FF, acc: cyc + 1});
        r = 1;
      end
      @(negedge clk);
      t++;
    end
    if (r == 0) chk("ready_return_timeout", 1, 0);
    release_v(1);
    drain();
`endif

    drive(0, 9'h03C, acc);
`ifdef UART_TX_FIFO_EN
    drive(0, 9'h0C3, a0);
    drive(0, 9'h05A, a0);
`endif
    release_v(0);
    t = 0;
    while (cyc < acc + LAT + 4 * CD + 1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    #2 n_rst = 1'b0;
    #1;
    chk("abort_tx_out", int'(tx_out[0]), 1);
    chk("abort_busy", int'(busy[0]), 0);
    chk("abort_ready", int'(tx_ready[0]), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2 n_rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_busy", int'(busy[0]), 0);
    chk("post_rst_ready", int'(tx_ready[0]), 1);
    @(negedge clk);
    drive(0, 9'h096, acc); release_v(0); drain();

    for (int i = 0; i < NI; i++) begin
      for (int n = 0; n < 8; n++) begin
        drive(i, 9'($urandom), acc);
        gap = $urandom_range(0, 3);
        if (gap > 0) begin
          release_v(i);
          repeat (gap) @(negedge clk);
        end
      end
      release_v(i);
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
